tour_cmd: RTL



---
 rtl/tour_cmd.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/tour_cmd.sv
// Walks a solved 5x5 knight's tour and turns each one-hot move into a vertical then horizontal motion command.
// Optional host-command pass-through while idle: define TOUR_CMD_MUX_EN.
module tour_cmd #(
   parameter int NUM_MOVES = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [7:0]  resp,
   output logic        tour_busy,
   output logic        tour_err
`ifdef TOUR_CMD_MUX_EN
   ,
   input  logic [15:0] cmd_ext,
   input  logic        cmd_ext_rdy,
   output logic        clr_ext_rdy
`endif
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      VERT,
      WAIT_V,
      HORZ,
      WAIT_H
   } state_t;

   localparam logic [4:0] LAST_INDX = 5'(NUM_MOVES - 1);

   state_t      state_reg, state_next;
   logic [4:0]  mv_indx_reg, mv_indx_next;
   logic        cmd_rdy_reg, cmd_rdy_next;
   logic        busy_reg, busy_next;
   logic        err_reg, err_next;
   logic [7:0]  resp_reg, resp_next;
   logic [7:0]  move_reg, move_next;
   logic        move_onehot;
   logic        north, vert_two, east, horz_two;
   logic [15:0] tour_cmd_word;

   assign move_onehot = (move != 8'h00) && ((move & (move - 8'd1)) == 8'h00);

   // Direction and length of each segment, grouped by which move bits share them.
   assign north    = move_reg[0] | move_reg[1] | move_reg[2] | move_reg[7];
   assign vert_two = move_reg[0] | move_reg[1] | move_reg[4] | move_reg[5];
   assign east     = move_reg[1] | move_reg[5] | move_reg[6] | move_reg[7];
   assign horz_two = move_reg[2] | move_reg[3] | move_reg[6] | move_reg[7];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         mv_indx_reg <= 5'd0;
         cmd_rdy_reg <= 1'b0;
         busy_reg    <= 1'b0;
         err_reg     <= 1'b0;
         resp_reg    <= 8'hA5;
         move_reg    <= 8'h00;
      end else begin
         state_reg   <= state_next;
         mv_indx_reg <= mv_indx_next;
         cmd_rdy_reg <= cmd_rdy_next;
         busy_reg    <= busy_next;
         err_reg     <= err_next;
         resp_reg    <= resp_next;
         move_reg    <= move_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      mv_indx_next = mv_indx_reg;
      cmd_rdy_next = cmd_rdy_reg;
      busy_next    = busy_reg;
      err_next     = 1'b0;
      resp_next    = resp_reg;
      move_next    = move_reg;
      case (state_reg)
         IDLE: begin
            if (start_tour) begin
               mv_indx_next = 5'd0;
               busy_next    = 1'b1;
               state_next   = LOAD;
            end
         end
         LOAD: begin
            // mv_indx has been stable for a full cycle, so the solver's read is settled.
            move_next = move;
            if (!move_onehot) begin
               err_next   = 1'b1;
               busy_next  = 1'b0;
               state_next = IDLE;
            end else begin
               cmd_rdy_next = 1'b1;
               state_next   = VERT;
            end
         end
         VERT: begin
            if (clr_cmd_rdy) begin
               cmd_rdy_next = 1'b0;
               state_next   = WAIT_V;
            end
         end
         WAIT_V: begin
            if (send_resp) begin
               cmd_rdy_next = 1'b1;
               state_next   = HORZ;
            end
         end
         HORZ: begin
            if (clr_cmd_rdy) begin
               cmd_rdy_next = 1'b0;
               state_next   = WAIT_H;
            end
         end
         WAIT_H: begin
            if (send_resp) begin
               if (mv_indx_reg == LAST_INDX) begin
                  resp_next  = 8'hA5;
                  busy_next  = 1'b0;
                  state_next = IDLE;
               end else begin
                  resp_next    = 8'h5A;
                  mv_indx_next = mv_indx_reg + 5'd1;
                  state_next   = LOAD;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      tour_cmd_word = 16'h0000;
      case (state_reg)
         VERT, WAIT_V: tour_cmd_word = {4'h4, north ? 8'h00 : 8'h7F, vert_two ? 4'd2 : 4'd1};
         HORZ, WAIT_H: tour_cmd_word = {4'h5, east ? 8'hBF : 8'h3F, horz_two ? 4'd2 : 4'd1};
         default:      tour_cmd_word = 16'h0000;
      endcase
   end

`ifdef TOUR_CMD_MUX_EN
   assign cmd         = (state_reg == IDLE) ? cmd_ext : tour_cmd_word;
   assign cmd_rdy     = (state_reg == IDLE) ? cmd_ext_rdy : cmd_rdy_reg;
   assign clr_ext_rdy = (state_reg == IDLE) ? clr_cmd_rdy : 1'b0;
`else
   assign cmd     = tour_cmd_word;
   assign cmd_rdy = cmd_rdy_reg;
`endif

   assign mv_indx   = mv_indx_reg;
   assign resp      = resp_reg;
   assign tour_busy = busy_reg;
   assign tour_err  = err_reg;

endmodule
